// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: streams host words to sequential addresses, holding the CPU until done.
// Optional trailing checksum word is enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [15:0] WordCount,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] InData,
    output logic        MemWrite,
    output logic [31:0] MemAddr,
    output logic [31:0] MemData,
    output logic        CpuHold,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    localparam int          KW        = $clog2(MAX_WORDS) + 1;
    localparam logic [31:0] MAX_WORDS32 = 32'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    state_t        state;
    logic [KW-1:0] k;
    logic [KW-1:0] cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   sum;
    logic          ck_bad;
`endif
    logic          xfer;
    logic          bad_count;
    logic          last_word;

    assign xfer      = InValid && InReady;
    assign bad_count = (WordCount == 16'd0) || ({16'd0, WordCount} > MAX_WORDS32);
    assign last_word = (k == cnt - KW'(1));
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign ck_bad    = (InData != sum);
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= IDLE;
            InReady  <= 1'b0;
            MemWrite <= 1'b0;
            MemAddr  <= 32'd0;
            MemData  <= 32'd0;
            CpuHold  <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Error    <= 1'b0;
        end else begin
            MemWrite <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        CpuHold <= 1'b1;
                        if (bad_count) begin
                            state   <= DONE;
                            Done    <= 1'b1;
                            Error   <= 1'b1;
                            InReady <= 1'b0;
                            Busy    <= 1'b0;
                        end else begin
                            state   <= LOAD;
                            Done    <= 1'b0;
                            Error   <= 1'b0;
                            InReady <= 1'b1;
                            Busy    <= 1'b1;
                            cnt     <= KW'(WordCount);
                            k       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            sum     <= 32'd0;
`endif
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        MemWrite <= 1'b1;
                        MemAddr  <= BASE_ADDR + (32'(k) << 2);
                        MemData  <= InData;
                        k        <= k + KW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum      <= sum + InData;
                        if (last_word)
                            state <= CHECK;
`else
                        // Done and CpuHold release land with the final strobe.
                        if (last_word) begin
                            state   <= DONE;
                            InReady <= 1'b0;
                            Busy    <= 1'b0;
                            Done    <= 1'b1;
                            Error   <= 1'b0;
                            CpuHold <= 1'b0;
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    // Checksum word is consumed but never written to memory.
                    if (xfer) begin
                        state   <= DONE;
                        InReady <= 1'b0;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Error   <= ck_bad;
                        CpuHold <= ck_bad;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes/completions, a monitor pops and compares.
// Also exercises the checksum path when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 8;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] WordCount = 16'd0;
    logic        InValid = 1'b0;
    logic [31:0] InData = 32'd0;
    logic        InReady, MemWrite, CpuHold, Busy, Done, Error;
    logic [31:0] MemAddr, MemData;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .WordCount(WordCount),
        .InValid(InValid), .InReady(InReady), .InData(InData),
        .MemWrite(MemWrite), .MemAddr(MemAddr), .MemData(MemData),
        .CpuHold(CpuHold), .Busy(Busy), .Done(Done), .Error(Error)
    );

    typedef struct {logic [31:0] addr; logic [31:0] data; int c;} wr_t;
    typedef struct {logic err; logic hold; int c;} dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  model_idx;
    int  model_n;
    logic [31:0] model_sum;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_inready"}, InReady, 0);
        check({tag, "_memwrite"}, MemWrite, 0);
        check({tag, "_memaddr"}, MemAddr, 0);
        check({tag, "_memdata"}, MemData, 0);
        check({tag, "_cpuhold"}, CpuHold, 1);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_done"}, Done, 0);
        check({tag, "_error"}, Error, 0);
    endtask

    // Monitor: compares every write strobe and every completion against the queues.
    initial begin
        wr_t w;
        dn_t d;
        logic pd;
        pd = 1'b0;
        forever begin
            @(negedge Clk);
            while (wq.size() != 0 && wq[0].c < cyc) begin
                w = wq.pop_front();
                tests++; fails++;
                $display("FAIL missed_write: no strobe, expected addr %h data %h at cycle %0d", w.addr, w.data, w.c);
            end
            while (dq.size() != 0 && dq[0].c < cyc) begin
                d = dq.pop_front();
                tests++; fails++;
                $display("FAIL missed_done: Done never rose, expected completion at cycle %0d", d.c);
            end
            if (MemWrite) begin
                if (wq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: addr %h data %h, expected no write", MemAddr, MemData);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", MemAddr, w.addr);
                    check("wr_data", MemData, w.data);
                    check("wr_cycle", cyc, w.c);
                end
            end
            if (dq.size() != 0 && dq[0].c == cyc) begin
                d = dq.pop_front();
                check("done", Done, 1);
                check("error", Error, d.err);
                check("cpuhold", CpuHold, d.hold);
            end else if (Done && !pd) begin
                tests++; fails++;
                $display("FAIL unexpected_done: Done=1 error %b, expected Done=0", Error);
            end
            pd = Done;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        InValid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_start(input logic [15:0] n);
        logic legal;
        legal = (n != 16'd0) && (int'(n) <= MAXW);
        Start = 1'b1;
        WordCount = n;
        if (!legal) dq.push_back('{err: 1'b1, hold: 1'b1, c: cyc + 1});
        model_idx = 0;
        model_n   = int'(n);
        model_sum = 32'd0;
        tick();
        Start = 1'b0;
        check("start_inready", InReady, legal);
        check("start_busy", Busy, legal);
        check("start_done", Done, !legal);
        check("start_error", Error, !legal);
        check("start_cpuhold", CpuHold, 1);
    endtask

    // Offers one word until accepted; is_data selects program word vs checksum word.
    task automatic send(input logic [31:0] w, input logic is_data);
        int waited;
        logic bad;
        waited = 0;
        InValid = 1'b1;
        InData  = w;
        while (!InReady && waited < 50) begin
            tick();
            waited++;
        end
        if (!InReady) begin
            tests++; fails++;
            $display("FAIL handshake_timeout: InReady stayed 0, expected 1");
        end else begin
            if (is_data) begin
                wq.push_back('{addr: BASE + 32'(model_idx) * 32'd4, data: w, c: cyc + 1});
                model_idx++;
                model_sum = model_sum + w;
`ifndef IMEM_LOADER_CHECKSUM_EN
                if (model_idx == model_n) dq.push_back('{err: 1'b0, hold: 1'b0, c: cyc + 1});
`endif
            end else begin
                bad = (w != model_sum);
                dq.push_back('{err: bad, hold: bad, c: cyc + 1});
            end
            tick();
        end
        InValid = 1'b0;
    endtask

    task automatic finish_image(input logic corrupt);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(corrupt ? model_sum + 32'd1 : model_sum, 1'b0);
`else
        if (corrupt) idle(0);
`endif
    endtask

    task automatic random_load(input int n, input int gap_pct);
        do_start(16'(n));
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
            send($urandom, 1'b1);
        end
        finish_image($urandom_range(0, 2) == 0);
        idle(2);
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        check_reset_vals("reset");
        Reset_n = 1'b1;
        tick();
        check_reset_vals("idle");

        // Basic load, back-to-back
        do_start(16'd3);
        send(32'h2001_0005, 1'b1);
        send(32'h2002_0007, 1'b1);
        send(32'h0022_1820, 1'b1);
        finish_image(1'b0);
        idle(3);

        // Stalled host: valid 1,0,0,1,1
        do_start(16'd3);
        send(32'hAAAA_0001, 1'b1);
        idle(2);
        send(32'hAAAA_0002, 1'b1);
        send(32'hAAAA_0003, 1'b1);
        finish_image(1'b0);
        idle(3);

        // Illegal counts, second issued from DONE
        do_start(16'd0);
        idle(2);
        do_start(16'(MAXW + 1));
        idle(2);
        do_start(16'hFFFF);
        idle(2);

        // Largest legal image
        random_load(MAXW, 0);

        // Start in LOAD is ignored; Start in DONE restarts
        do_start(16'd3);
        send(32'h0000_1111, 1'b1);
        Start = 1'b1;
        WordCount = 16'd0;
        tick();
        Start = 1'b0;
        check("ignored_start_busy", Busy, 1);
        check("ignored_start_inready", InReady, 1);
        send(32'h0000_2222, 1'b1);
        send(32'h0000_3333, 1'b1);
        finish_image(1'b0);
        idle(1);
        do_start(16'd2);
        send(32'h0000_4444, 1'b1);
        send(32'h0000_5555, 1'b1);
        finish_image(1'b0);
        idle(2);

        // Reset during load: pending write from third transfer must be dropped
        do_start(16'd4);
        send(32'hBEEF_0001, 1'b1);
        send(32'hBEEF_0002, 1'b1);
        InValid = 1'b1;
        InData  = 32'hBEEF_0003;
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        InValid = 1'b0;
        check_reset_vals("midreset");
        idle(2);
        do_start(16'd2);
        send(32'hCAFE_0001, 1'b1);
        send(32'hCAFE_0002, 1'b1);
        finish_image(1'b0);
        idle(2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        do_start(16'd3);
        send(32'd1, 1'b1);
        send(32'd2, 1'b1);
        send(32'd3, 1'b1);
        send(32'd6, 1'b0);
        idle(2);
        do_start(16'd3);
        send(32'd1, 1'b1);
        send(32'd2, 1'b1);
        send(32'd3, 1'b1);
        send(32'd7, 1'b0);
        idle(2);
`endif

        // Randomized loads with occasional illegal counts
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 5) == 0) begin
                do_start($urandom_range(0, 1) == 0 ? 16'd0 : 16'(MAXW + 1 + $urandom_range(0, 100)));
                idle(2);
            end else begin
                random_load($urandom_range(1, MAXW), 40);
            end
        end

        idle(4);
        check("pending_writes", wq.size(), 0);
        check("pending_dones", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes a program image into the CPU's instruction memory before execution begins. A host streams 32-bit instruction words over a valid/ready handshake. The block writes them to sequential word addresses and holds the CPU stalled until the image is complete. It sits between the bench/host stimulus and the CPU's instruction-memory write port, and is the write side of the path the CPU fetches from.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first program word.
- `MAX_WORDS`, default 256: largest accepted image size in words.
- `Clk`  in  1  the single clock; all logic is rising-edge.
- `Reset_n`  in  1  synchronous, active-low reset, sampled on rising `Clk`.
- `Start`  in  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- `WordCount`  in  16  image size in words; latched on the accepted `Start`.
- `InValid`  in  1  host has a word on `InData`.
- `InReady`  out  1  loader accepts a word; transfer occurs when `InValid && InReady`.
- `InData`  in  32  instruction word.
- `MemWrite`  out  1  one-cycle instruction-memory write strobe.
- `MemAddr`  out  32  byte address of the write.
- `MemData`  out  32  data of the write.
- `CpuHold`  out  1  stalls the CPU (PC and pipeline frozen) while high.
- `Busy`  out  1  high in LOAD or CHECK.
- `Done`  out  1  level; the load attempt has finished.
- `Error`  out  1  level; valid while `Done` is high.

## Operation
- States: IDLE, LOAD, CHECK (present only with the macro), DONE.
- IDLE, accepted `Start`:
  - If `WordCount == 0` or `WordCount > MAX_WORDS`: go to DONE with `Error=1` and perform no writes.
  - Otherwise: latch the count, clear the word index k and the checksum, and go to LOAD.
- LOAD:
  - `InReady=1`.
  - On each transfer, the next cycle registers `MemWrite=1`, `MemAddr = BASE_ADDR + 4*k` and `MemData = InData`, then k increments.
  - After the transfer with k = count-1, go to CHECK if the macro is defined, otherwise to DONE with `Error=0`.
- DONE:
  - `Done=1`, `InReady=0`.
  - `CpuHold=0` only if `Error=0`.
  - An accepted `Start` re-enters the flow: it clears `Done` and `Error`, sets `CpuHold=1`, and is treated exactly as `Start` in IDLE.
- `Start` in LOAD or CHECK is ignored.
- `InValid` outside LOAD/CHECK is ignored and no transfer occurs.
- Address arithmetic is modulo 2^32, so wrap past 32'hFFFF_FFFC is silent.
- k width is clog2(MAX_WORDS)+1.

## Timing
- Reset values: state=IDLE, `InReady=0`, `MemWrite=0`, `MemAddr=0`, `MemData=0`, `CpuHold=1`, `Busy=0`, `Done=0`, `Error=0`.
- Latency:
  - `Start` in cycle N puts the block in LOAD with `InReady=1` in cycle N+1.
  - A transfer in cycle T produces `MemWrite` in cycle T+1.
- Throughput is one word per cycle. `InReady` stays high through back-to-back transfers, and `MemWrite` pulses every cycle.
- The final write strobe and the `Done` rise occur in the same cycle. `CpuHold` falls in that cycle too, so the CPU's first fetch sees a completed memory.
- Reset asserted mid-load: the next edge returns every output to its reset value. The partial image is abandoned and the pending `MemWrite` is dropped.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The loader keeps `Sum = Σ words mod 2^32` over the program words.
  - After the last program word it enters CHECK with `InReady=1` and accepts exactly one checksum word. This word is never written to memory.
  - `Error = (checksum != Sum)`. Go to DONE one cycle after that transfer.
- Not defined: CHECK and the summing logic do not exist. `Error` is set only by an illegal `WordCount`.

## Test plan
- **Basic load.** Reset, then `Start` with `WordCount=3`, then words `0x20010005`, `0x20020007`, `0x00221820` back-to-back. Required response:
  - Writes to addresses 0x0, 0x4, 0x8 in three consecutive cycles.
  - `Done=1`, `Error=0` and `CpuHold` falls with the third strobe.
- **Stalled host.** `InValid` toggles 1,0,0,1,1 for `WordCount=3`. Required response:
  - `MemWrite` appears only one cycle after each transfer.
  - Addresses stay sequential with no gaps.
- **Illegal counts.** `Start` with `WordCount=0`, then with `WordCount=MAX_WORDS+1`. Required response: for each, no `MemWrite`, `Done=1`, `Error=1` and `CpuHold=1`.
- **Reset mid-load.** Drop `Reset_n` after 2 of 4 words. Required response:
  - All outputs return to reset values one edge later.
  - A new `Start` reloads from `BASE_ADDR`.
- **Checksum (macro on).** Words 1, 2, 3 with checksum 6 -> `Error=0`, and the checksum word is not written. Repeating with checksum 7 -> `Error=1` and `CpuHold` stays 1.
- **Reload.** `Start` pulsed in LOAD is ignored. `Start` pulsed in DONE restarts the load with `CpuHold` back to 1.
